// File: rtl/scan_chain_ctl.sv
// scan_chain_ctl
//   Register bank plus serial scan controller feeding the D inputs of a row
//   of sff1-class flip-flops. In IDLE the bank captures d when func_en is
//   high. A scan_start pulse in IDLE runs exactly WIDTH right shifts: sdi
//   enters at the MSB and q[0] leaves on sdo. The block then spends one
//   cycle in DONE and returns to IDLE.
//
// Ports
//   ck          clock, rising edge
//   nrst        asynchronous active-low reset
//   d           functional parallel data
//   func_en     functional capture enable, sampled only in IDLE
//   scan_start  request one full WIDTH-bit shift, sampled only in IDLE
//   sdi         serial scan data in (enters q[WIDTH-1])
//   q           register bank contents
//   sdo         serial scan data out, combinational copy of q[0]
//   busy        high while shifting
//   done        one-cycle pulse after the last shift
module scan_chain_ctl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  input  logic             func_en,
  input  logic             scan_start,
  input  logic             sdi,
  output logic [WIDTH-1:0] q,
  output logic             sdo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] cnt;
  logic            last_shift;

  // The counter holds the number of shifts already completed, so the edge
  // on which it equals WIDTH-1 performs the WIDTH-th shift.
  assign last_shift = (cnt == CNTW'(WIDTH - 1));

  // State register
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (scan_start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift counter: cleared when a scan is accepted, counts every shift edge.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (scan_start) begin
            cnt <= '0;
          end
        end
        SHIFT: begin
          cnt <= cnt + CNTW'(1);
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  // Register bank. scan_start wins over func_en in IDLE: the accepting edge
  // leaves q untouched so the first shift still sees the pre-scan contents.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!scan_start && func_en) begin
            q <= d;
          end
        end
        SHIFT: begin
          q <= {sdi, q[WIDTH-1:1]};
        end
        default: begin
          q <= q;
        end
      endcase
    end
  end

  assign sdo = q[0];

endmodule

// File: tb/tb_scan_chain_ctl.sv
module tb_scan_chain_ctl;

  localparam int WIDTH = 8;

  logic             ck;
  logic             nrst;
  logic [WIDTH-1:0] d;
  logic             func_en;
  logic             scan_start;
  logic             sdi;
  logic [WIDTH-1:0] q;
  logic             sdo;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues filled by stimulus, drained by the monitor.
  logic             exp_sdo_q[$];
  logic [WIDTH-1:0] exp_q_q[$];
  int               exp_gap_q[$];

  scan_chain_ctl #(.WIDTH(WIDTH)) dut (
    .ck         (ck),
    .nrst       (nrst),
    .d          (d),
    .func_en    (func_en),
    .scan_start (scan_start),
    .sdi        (sdi),
    .q          (q),
    .sdo        (sdo),
    .busy       (busy),
    .done       (done)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic push_scan(input logic [WIDTH-1:0] pre, input logic [WIDTH-1:0] post);
    logic [WIDTH-1:0] p;
    p = pre;
    for (int i = 0; i < WIDTH; i++) exp_sdo_q.push_back(p[i]);
    exp_q_q.push_back(post);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  int busy_run = 0;
  int low_run  = 0;
  logic prev_busy = 1'b0;

  always @(negedge ck) begin
    if (!nrst) begin
      busy_run  = 0;
      low_run   = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        if (!prev_busy && exp_gap_q.size() > 0) begin
          check("busy_gap", 64'(low_run), 64'(exp_gap_q.pop_front()));
        end
        busy_run++;
        low_run = 0;
        if (exp_sdo_q.size() == 0) begin
          check("unexpected_busy", 64'(1), 64'(0));
        end else begin
          check("sdo", 64'(sdo), 64'(exp_sdo_q.pop_front()));
        end
      end else begin
        low_run++;
      end
      if (done) begin
        check("done_busy_len", 64'(busy_run), 64'(WIDTH));
        check("done_busy_low", 64'(busy), 64'(0));
        busy_run = 0;
        if (exp_q_q.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          check("q_after_scan", 64'(q), 64'(exp_q_q.pop_front()));
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] seq;

  initial begin
    nrst = 1'b0; d = '0; func_en = 1'b0; scan_start = 1'b0; sdi = 1'b0;
    #2;
    check("rst_q", 64'(q), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    tick(); tick();
    nrst = 1'b1;
    tick();

    // Asynchronous reset mid-cycle with q = A5
    func_en = 1'b1; d = 8'hA5;
    tick();
    func_en = 1'b0;
    check("cap_a5", 64'(q), 64'hA5);
    check("cap_a5_sdo", 64'(sdo), 64'(1));
    #2 nrst = 1'b0;
    #1;
    check("async_q", 64'(q), 64'(0));
    check("async_busy", 64'(busy), 64'(0));
    check("async_done", 64'(done), 64'(0));
    check("async_sdo", 64'(sdo), 64'(0));
    tick();
    nrst = 1'b1;
    tick();

    // Functional capture, then hold with func_en low
    func_en = 1'b1; d = 8'h3C;
    tick();
    check("cap_3c", 64'(q), 64'h3C);
    check("cap_3c_sdo", 64'(sdo), 64'(0));
    func_en = 1'b0; d = 8'hFF;
    tick();
    check("hold_3c", 64'(q), 64'h3C);

    // Full scan: q=96, sdi 1,0,1,1,0,0,1,0 -> sdo 0,1,1,0,1,0,0,1, q=4D
    func_en = 1'b1; d = 8'h96;
    tick();
    func_en = 1'b0;
    check("cap_96", 64'(q), 64'h96);
    push_scan(8'h96, 8'h4D);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("scan_busy1", 64'(busy), 64'(1));
    seq = 8'b0100_1101;           // seq[i] = sdi for shift i
    for (int i = 0; i < WIDTH; i++) begin
      sdi = seq[i];
      tick();
    end
    check("scan_done_state", 64'(done), 64'(1));
    tick();
    check("scan_idle_busy", 64'(busy), 64'(0));
    check("scan_idle_done", 64'(done), 64'(0));
    check("scan_q_4d", 64'(q), 64'h4D);

    // Priority: scan_start beats func_en; mid-scan scan_start is ignored
    func_en = 1'b1; d = 8'h12;
    tick();
    push_scan(8'h12, 8'hFF);
    scan_start = 1'b1; func_en = 1'b1; d = 8'hFF; sdi = 1'b1;
    tick();
    scan_start = 1'b0; func_en = 1'b0;
    check("prio_q_held", 64'(q), 64'h12);
    check("prio_busy", 64'(busy), 64'(1));
    for (int i = 0; i < WIDTH; i++) begin
      scan_start = (i == 3);
      func_en    = (i == 5);
      tick();
    end
    scan_start = 1'b0; func_en = 1'b0;
    check("prio_done", 64'(done), 64'(1));
    tick();
    check("prio_q_ff", 64'(q), 64'hFF);
    tick(); tick();
    check("prio_idle", 64'(busy), 64'(0));

    // Reset after the 3rd shift: abort, q cleared, no done pulse
    func_en = 1'b1; d = 8'hA5;
    tick();
    func_en = 1'b0;
    push_scan(8'hA5, 8'h00);
    exp_q_q.delete();             // aborted scan produces no done
    scan_start = 1'b1; sdi = 1'b0;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("mid_q_before", 64'(q), 64'h14);
    #2 nrst = 1'b0;
    exp_sdo_q.delete();
    #1;
    check("mid_rst_q", 64'(q), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("mid_idle", 64'(busy), 64'(0));
    // New scan from q=0 with sdi pattern -> q=C6
    push_scan(8'h00, 8'hC6);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    seq = 8'hC6;
    for (int i = 0; i < WIDTH; i++) begin
      sdi = seq[i];
      tick();
    end
    tick();
    check("post_rst_q", 64'(q), 64'hC6);

    // Back-to-back with scan_start held: 0F -> 00 (sdi=0), then 00 -> FF (sdi=1)
    func_en = 1'b1; d = 8'h0F;
    tick();
    func_en = 1'b0;
    push_scan(8'h0F, 8'h00);
    push_scan(8'h00, 8'hFF);
    scan_start = 1'b1; sdi = 1'b0;
    for (int i = 0; i <= 2 * WIDTH + 3; i++) begin
      tick();
      if (i == 1) exp_gap_q.push_back(2);
      if (i == WIDTH + 1) sdi = 1'b1;
      if (i == WIDTH + 2) scan_start = 1'b0;
    end
    check("b2b_q", 64'(q), 64'hFF);
    check("b2b_busy", 64'(busy), 64'(0));
    tick(); tick();

    check("sdo_queue_empty", 64'(exp_sdo_q.size()), 64'(0));
    check("q_queue_empty", 64'(exp_q_q.size()), 64'(0));
    check("gap_queue_empty", 64'(exp_gap_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
